// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
//   Byte-wide memory copy / fill engine driving a single-port data memory
//   with combinational read data. One accepted start performs either an
//   ascending read-then-write copy of i_len bytes from i_srcAddr to
//   i_dstAddr, or a fill of i_len bytes at i_dstAddr with i_fillValue.
//   All pointer and checksum arithmetic wraps modulo 256.
//
// Ports
//   i_clk             rising-edge clock
//   i_resetN          synchronous active-low reset
//   i_start           request pulse, only sampled in IDLE
//   i_mode            0 = copy, 1 = fill
//   i_srcAddr         first source byte address (copy)
//   i_dstAddr         first destination byte address
//   i_len             byte count, 0 = no transfer
//   i_fillValue       fill byte (fill)
//   i_memReadData     combinational read data at o_memAddr
//   o_memAddr         data-memory address
//   o_memWriteData    data-memory write data
//   o_memWriteEnable  data-memory write strobe
//   o_busy            high in READ, WRITE and FILL
//   o_done            one-cycle completion pulse
//   o_checksum        mod-256 sum of bytes moved by the last operation
// ---------------------------------------------------------------------------
module mem_copy_engine (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic       i_start,
    input  logic       i_mode,
    input  logic [7:0] i_srcAddr,
    input  logic [7:0] i_dstAddr,
    input  logic [7:0] i_len,
    input  logic [7:0] i_fillValue,
    input  logic [7:0] i_memReadData,
    output logic [7:0] o_memAddr,
    output logic [7:0] o_memWriteData,
    output logic       o_memWriteEnable,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;

    logic [7:0] r_srcPtr;
    logic [7:0] r_dstPtr;
    logic [7:0] r_remaining;
    logic       r_mode;
    logic [7:0] r_fill;
    logic [7:0] r_hold;
    logic [7:0] r_checksum;

    logic [7:0] w_memAddr;
    logic [7:0] w_memWriteData;
    logic       w_memWriteEnable;
    logic       w_busy;
    logic       w_done;
    logic       w_lastByte;

    assign w_lastByte = (r_remaining == 8'd1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_nextState      = r_state;
        w_memAddr        = '0;
        w_memWriteData   = '0;
        w_memWriteEnable = 1'b0;
        w_busy           = 1'b0;
        w_done           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len == 8'd0) begin
                        w_nextState = S_DONE;
                    end else if (i_mode) begin
                        w_nextState = S_FILL;
                    end else begin
                        w_nextState = S_READ;
                    end
                end
            end
            S_READ: begin
                w_busy      = 1'b1;
                w_memAddr   = r_srcPtr;
                w_nextState = S_WRITE;
            end
            S_WRITE, S_FILL: begin
                // Both write states share the data mux; the latched mode
                // picks the held read byte or the fill byte.
                w_busy           = 1'b1;
                w_memAddr        = r_dstPtr;
                w_memWriteData   = r_mode ? r_fill : r_hold;
                w_memWriteEnable = 1'b1;
                if (w_lastByte) begin
                    w_nextState = S_DONE;
                end else if (r_state == S_WRITE) begin
                    w_nextState = S_READ;
                end else begin
                    w_nextState = S_FILL;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_srcPtr    <= '0;
            r_dstPtr    <= '0;
            r_remaining <= '0;
            r_mode      <= 1'b0;
            r_fill      <= '0;
            r_hold      <= '0;
            r_checksum  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_srcPtr    <= i_srcAddr;
                        r_dstPtr    <= i_dstAddr;
                        r_remaining <= i_len;
                        r_mode      <= i_mode;
                        r_fill      <= i_fillValue;
                        r_checksum  <= '0;
                    end
                end
                S_READ: begin
                    r_hold     <= i_memReadData;
                    r_checksum <= r_checksum + i_memReadData;
                end
                S_WRITE: begin
                    r_srcPtr    <= r_srcPtr + 8'd1;
                    r_dstPtr    <= r_dstPtr + 8'd1;
                    r_remaining <= r_remaining - 8'd1;
                end
                S_FILL: begin
                    r_checksum  <= r_checksum + r_fill;
                    r_dstPtr    <= r_dstPtr + 8'd1;
                    r_remaining <= r_remaining - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The strobe is qualified by reset so an abort in a write state
    // cannot commit a byte on the resetting edge.
    assign o_memAddr        = w_memAddr;
    assign o_memWriteData   = w_memWriteData;
    assign o_memWriteEnable = w_memWriteEnable & i_resetN;
    assign o_busy           = w_busy;
    assign o_done           = w_done;
    assign o_checksum       = r_checksum;

endmodule

// File: tb/tb_mem_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_engine
//   Directed bench for mem_copy_engine with a 256-byte behavioural memory.
// ---------------------------------------------------------------------------
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       mode;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] len;
    logic [7:0] fillValue;
    logic [7:0] memReadData;
    logic [7:0] memAddr;
    logic [7:0] memWriteData;
    logic       memWriteEnable;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    logic [7:0] mem [256];
    logic       tbWe;
    logic [7:0] tbAddr;
    logic [7:0] tbData;

    int compared   = 0;
    int mismatched = 0;

    int busyCnt;
    int doneCyc;
    bit weSeen;

    mem_copy_engine dut (
        .i_clk            (clk),
        .i_resetN         (resetN),
        .i_start          (start),
        .i_mode           (mode),
        .i_srcAddr        (srcAddr),
        .i_dstAddr        (dstAddr),
        .i_len            (len),
        .i_fillValue      (fillValue),
        .i_memReadData    (memReadData),
        .o_memAddr        (memAddr),
        .o_memWriteData   (memWriteData),
        .o_memWriteEnable (memWriteEnable),
        .o_busy           (busy),
        .o_done           (done),
        .o_checksum       (checksum)
    );

    always #5 clk = ~clk;

    assign memReadData = mem[memAddr];

    always @(posedge clk) begin
        if (memWriteEnable) begin
            mem[memAddr] <= memWriteData;
        end else if (tbWe) begin
            mem[tbAddr] <= tbData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Writes one byte into the memory model through the bench port.
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tbAddr = a;
        tbData = d;
        tbWe   = 1'b1;
        @(negedge clk);
        tbWe   = 1'b0;
    endtask

    // Presents a request at a negedge; it is accepted at the next posedge.
    task automatic launch(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] n, input logic [7:0] f);
        start     = 1'b1;
        mode      = m;
        srcAddr   = s;
        dstAddr   = d;
        len       = n;
        fillValue = f;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Observes cycles after the accepting edge (cycle 1 is the first).
    // With disturb set, a conflicting fill request is pulsed while busy
    // and again during the done cycle.
    task automatic observe(input bit disturb);
        busyCnt = 0;
        doneCyc = 0;
        weSeen  = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (busy) busyCnt++;
            if (memWriteEnable) weSeen = 1'b1;
            if (done) begin
                doneCyc = i;
                if (disturb) begin
                    start = 1'b1; mode = 1'b1; dstAddr = 8'h10; len = 8'd1; fillValue = 8'hFF;
                end
                break;
            end
            if (disturb && i == 2) begin
                start = 1'b1; mode = 1'b1; srcAddr = 8'h00; dstAddr = 8'h10; len = 8'd1; fillValue = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (doneCyc == 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; mode = 1'b0; srcAddr = '0; dstAddr = '0;
        len = '0; fillValue = '0; tbWe = 1'b0; tbAddr = '0; tbData = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_addr",  {24'd0, memAddr}, 32'h0);
        check("rst_wdata", {24'd0, memWriteData}, 32'h0);
        check("rst_we",    {31'd0, memWriteEnable}, 32'h0);
        check("rst_busy",  {31'd0, busy}, 32'h0);
        check("rst_done",  {31'd0, done}, 32'h0);
        check("rst_csum",  {24'd0, checksum}, 32'h0);

        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33);
        poke(8'h20, 8'h7E); poke(8'h21, 8'h00);
        poke(8'h40, 8'h01); poke(8'h41, 8'h02); poke(8'h42, 8'h03);
        resetN = 1'b1;
        @(negedge clk);

        // Basic copy, 3 bytes
        launch(1'b0, 8'h10, 8'h80, 8'd3, 8'h00);
        observe(1'b0);
        check("copy_busy",  busyCnt, 32'd6);
        check("copy_done",  doneCyc, 32'd7);
        check("copy_csum",  {24'd0, checksum}, 32'h66);
        check("copy_m80",   {24'd0, mem[8'h80]}, 32'h11);
        check("copy_m81",   {24'd0, mem[8'h81]}, 32'h22);
        check("copy_m82",   {24'd0, mem[8'h82]}, 32'h33);
        check("copy_pulse", {31'd0, done}, 32'h0);
        @(negedge clk);
        check("copy_hold",  {24'd0, checksum}, 32'h66);

        // Fill wrapping past 0xFF
        launch(1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5);
        observe(1'b0);
        check("fill_busy", busyCnt, 32'd4);
        check("fill_done", doneCyc, 32'd5);
        check("fill_csum", {24'd0, checksum}, 32'h94);
        check("fill_mFE",  {24'd0, mem[8'hFE]}, 32'hA5);
        check("fill_mFF",  {24'd0, mem[8'hFF]}, 32'hA5);
        check("fill_m00",  {24'd0, mem[8'h00]}, 32'hA5);
        check("fill_m01",  {24'd0, mem[8'h01]}, 32'hA5);
        check("fill_m02",  {24'd0, mem[8'h02]}, 32'h00);

        // Zero length
        launch(1'b0, 8'h10, 8'hC0, 8'd0, 8'h00);
        observe(1'b0);
        check("zero_done", doneCyc, 32'd1);
        check("zero_busy", busyCnt, 32'd0);
        check("zero_we",   {31'd0, weSeen}, 32'h0);
        check("zero_csum", {24'd0, checksum}, 32'h0);

        // Overlapping copy propagates the written byte
        launch(1'b0, 8'h20, 8'h21, 8'd2, 8'h00);
        observe(1'b0);
        check("ovl_m21",  {24'd0, mem[8'h21]}, 32'h7E);
        check("ovl_m22",  {24'd0, mem[8'h22]}, 32'h7E);
        check("ovl_csum", {24'd0, checksum}, 32'hFC);

        // Abort in first WRITE cycle of a 3-byte copy
        launch(1'b0, 8'h40, 8'h50, 8'd3, 8'h00);
        check("abt_read", {31'd0, busy}, 32'h1);
        @(negedge clk);
        check("abt_inwr", {24'd0, memAddr}, 32'h50);
        resetN = 1'b0;
        #1;
        check("abt_we_gate", {31'd0, memWriteEnable}, 32'h0);
        @(negedge clk);
        check("abt_m50",   {24'd0, mem[8'h50]}, 32'h00);
        check("abt_addr",  {24'd0, memAddr}, 32'h0);
        check("abt_busy",  {31'd0, busy}, 32'h0);
        check("abt_done",  {31'd0, done}, 32'h0);
        check("abt_csum",  {24'd0, checksum}, 32'h0);
        // Start in the first cycle after reset release
        resetN = 1'b1;
        launch(1'b0, 8'h40, 8'h60, 8'd3, 8'h00);
        observe(1'b0);
        check("post_busy", busyCnt, 32'd6);
        check("post_done", doneCyc, 32'd7);
        check("post_csum", {24'd0, checksum}, 32'h06);
        check("post_m62",  {24'd0, mem[8'h62]}, 32'h03);
        check("post_m51",  {24'd0, mem[8'h51]}, 32'h00);

        // Start pulsed while busy and in the done cycle is ignored
        launch(1'b0, 8'h10, 8'h90, 8'd3, 8'h00);
        observe(1'b1);
        check("ign_busy", busyCnt, 32'd6);
        check("ign_done", doneCyc, 32'd7);
        check("ign_m92",  {24'd0, mem[8'h92]}, 32'h33);
        check("ign_idle", {31'd0, busy | done}, 32'h0);
        @(negedge clk);
        check("ign_none", {31'd0, busy | done}, 32'h0);
        check("ign_m10",  {24'd0, mem[8'h10]}, 32'h11);
        check("ign_csum", {24'd0, checksum}, 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
